// File: rtl/display_pkg.sv
// Shared display constants and types for the 480p pipeline stages.
package display_pkg;
  localparam int CORDW = 10;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  typedef logic [CORDW-1:0] coord_t;
  typedef enum logic {FWD = 1'b0, BACK = 1'b1} dir_t;
endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing square: position register plus FWD/BACK direction
// state, advanced by SPEED on each step and clamped at 0 and LIMIT-SIZE.
module bounce_axis
  import display_pkg::*;
#(
  parameter int LIMIT = H_RES,
  parameter int SIZE  = 200,
  parameter int SPEED = 1,
  parameter int P0    = 0
) (
  input  logic   clk_pix,
  input  logic   btn_rst_n,
  input  logic   step,
  output coord_t pos,
  output dir_t   dir
);

  localparam logic [CORDW:0] SPEED_W = (CORDW+1)'(SPEED);
  localparam logic [CORDW:0] MAX_W   = (CORDW+1)'(LIMIT - SIZE);
  localparam coord_t         P0_C    = CORDW'(P0);

  coord_t         pos_q, pos_d;
  dir_t           dir_q, dir_d;
  logic [CORDW:0] pos_ext;
  logic [CORDW:0] fwd_sum;

  // One extra bit keeps pos+SPEED from wrapping before the edge compare.
  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    pos_ext = {1'b0, pos_q};
    fwd_sum = pos_ext + SPEED_W;
    if (step) begin
      if (dir_q == FWD) begin
        if (fwd_sum >= MAX_W) begin
          pos_d = MAX_W[CORDW-1:0];
          dir_d = BACK;
        end else begin
          pos_d = fwd_sum[CORDW-1:0];
        end
      end else begin
        if (pos_ext <= SPEED_W) begin
          pos_d = '0;
          dir_d = FWD;
        end else begin
          pos_d = pos_q - SPEED_W[CORDW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      pos_q <= P0_C;
      dir_q <= FWD;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/square_motion.sv
// Per-frame square animation and registered inside-square test, with the
// timing-generator syncs delayed one stage to stay aligned with square_q.
module square_motion #(
  parameter int CORDW = 10,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int SIZE  = 200,
  parameter int SPEED = 1,
  parameter int X0    = 220,
  parameter int Y0    = 140
) (
  input  logic             clk_pix,
  input  logic             btn_rst_n,
  input  logic             run,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic             square_q,
  output logic             hsync_q,
  output logic             vsync_q,
  output logic             de_q,
  output logic             frame,
  output logic [CORDW-1:0] pos_x,
  output logic [CORDW-1:0] pos_y,
  output logic [1:0]       dir_dbg
);

  import display_pkg::dir_t;

  localparam logic [CORDW-1:0] V_RES_C = CORDW'(V_RES);
  localparam logic [CORDW:0]   SIZE_W  = (CORDW+1)'(SIZE);

  logic frame_start;
  logic step_en;
  logic in_x, in_y;
  logic square_d, frame_d;
  logic frame_q;
  dir_t dx, dy;

  // First blanking line, first pixel: position may change without tearing.
  assign frame_start = (sy == V_RES_C) && (sx == '0);
  assign step_en     = frame_start && run;

  bounce_axis #(
    .LIMIT (H_RES),
    .SIZE  (SIZE),
    .SPEED (SPEED),
    .P0    (X0)
  ) u_axis_x (
    .clk_pix   (clk_pix),
    .btn_rst_n (btn_rst_n),
    .step      (step_en),
    .pos       (pos_x),
    .dir       (dx)
  );

  bounce_axis #(
    .LIMIT (V_RES),
    .SIZE  (SIZE),
    .SPEED (SPEED),
    .P0    (Y0)
  ) u_axis_y (
    .clk_pix   (clk_pix),
    .btn_rst_n (btn_rst_n),
    .step      (step_en),
    .pos       (pos_y),
    .dir       (dy)
  );

  // Left/top inclusive, right/bottom exclusive.
  always_comb begin
    in_x     = ({1'b0, sx} >= {1'b0, pos_x}) && ({1'b0, sx} < ({1'b0, pos_x} + SIZE_W));
    in_y     = ({1'b0, sy} >= {1'b0, pos_y}) && ({1'b0, sy} < ({1'b0, pos_y} + SIZE_W));
    square_d = in_x && in_y;
    frame_d  = frame_start;
  end

  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      square_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      square_q <= square_d;
      hsync_q  <= hsync;
      vsync_q  <= vsync;
      de_q     <= de;
      frame_q  <= frame_d;
    end
  end

  assign frame   = frame_q;
  assign dir_dbg = {dy, dx};

endmodule

// File: doc/square_motion.md
# square_motion

Per-frame animation and pixel-test stage that sits between the 480p display timing generator and the colour painter/VGA output register in `top_square`. Holds the top-left position of a fixed-size square and moves it by a programmable step once per frame, during vertical blanking, bouncing off the screen edges. It also registers the "pixel is inside square" flag. To keep the flag aligned, it delays `hsync`, `vsync` and `de` through the same single pipeline stage.

## Interface
- `CORDW`, 10, screen coordinate width in bits
- `H_RES`, 640, active pixels per line
- `V_RES`, 480, active lines per frame
- `SIZE`, 200, square edge length in pixels
- `SPEED`, 1, pixels moved per frame on each axis; legal range 1 ≤ SPEED < min(H_RES,V_RES)−SIZE
- `X0`, 220, reset x position (top-left)
- `Y0`, 140, reset y position (top-left)

Ports:
- `clk_pix`  in  1  pixel clock
- `btn_rst_n`  in  1  reset; one clock, asynchronous assert, active-low
- `run`  in  1  1 = animate; 0 = freeze position
- `sx`  in  CORDW  current horizontal screen coordinate
- `sy`  in  CORDW  current vertical screen coordinate
- `hsync`  in  1  horizontal sync from timing generator
- `vsync`  in  1  vertical sync from timing generator
- `de`  in  1  data enable from timing generator
- `square_q`  out  1  pixel (sx,sy) lies inside square, registered
- `hsync_q`  out  1  `hsync` delayed 1 cycle
- `vsync_q`  out  1  `vsync` delayed 1 cycle
- `de_q`  out  1  `de` delayed 1 cycle
- `frame`  out  1  one-cycle pulse marking the position update
- `pos_x`  out  CORDW  current square x (top-left)
- `pos_y`  out  CORDW  current square y (top-left)

## Operation
- **Frame strobe**
  - Combinational `frame_start` = (sy == V_RES) && (sx == 0).
  - Fires exactly once per frame, on the first blanking line.
- **Position update**
  - Happens only on cycles with `frame_start && run`.
  - `frame` is registered and pulses high the cycle after `frame_start`, whether or not `run` is set.
- **Direction state**
  - Two registered bits: `dx` (0 = right, 1 = left) and `dy` (0 = down, 1 = up).
  - Each axis is an independent two-state FSM, FWD ↔ BACK.
- **X axis update rule** (Y is identical, with V_RES and `pos_y`)
  - Compute in CORDW+1 bits to avoid wrap.
  - If moving right and `pos_x + SPEED ≥ H_RES − SIZE`: `pos_x ← H_RES − SIZE`, `dx ← 1`.
  - If moving left and `pos_x ≤ SPEED`: `pos_x ← 0`, `dx ← 0`.
  - Otherwise: `pos_x ± SPEED`.
  - The edge frame clamps and flips direction in the same update; the next update moves away from the edge.
- **Inside test**
  - `pos_x ≤ sx < pos_x + SIZE` and `pos_y ≤ sy < pos_y + SIZE`, computed in CORDW+1 bits, then registered into `square_q`.
  - Left and top edges are inclusive; right and bottom edges are exclusive.
- **Position stability**
  - Position never changes while `sy < V_RES`, so no tearing occurs in the active area.
- **`run` behaviour**
  - `run` = 0 holds position and direction. `square_q` keeps tracking the held position.

## Timing
- **Reset values** (asynchronous, `btn_rst_n` = 0):
  - `pos_x` = X0, `pos_y` = Y0
  - `dx` = 0, `dy` = 0
  - `square_q`, `hsync_q`, `vsync_q`, `de_q`, `frame` = 0
- **Latency**: `square_q`, `hsync_q`, `vsync_q` and `de_q` have 1 clk_pix latency relative to inputs. Downstream consumes only the `_q` set.
- **Position update timing**: `pos_x`/`pos_y` update on the clock edge at `frame_start` and are visible the following cycle, in the same cycle as the `frame` pulse.
- **Reset mid-frame**: outputs go to reset values immediately. Normal operation resumes on the first clock edge after release, with no wait for a frame boundary.
- **`run` at the edge**: `run` sampled only at `frame_start`; toggling it at any other cycle has no effect.
- **Coincident bounce**: when both axes hit an edge on the same frame, both flip in that frame.

## Structure
- **Shared package** `display_pkg`:
  - CORDW
  - H_RES / V_RES constants
  - typedef `coord_t` = logic [CORDW-1:0]
  - enum `dir_t` {FWD, BACK}
- **Sub-module** `bounce_axis`:
  - Parameters: LIMIT, SIZE, SPEED, P0.
  - Ports: clk_pix, btn_rst_n, step, pos, dir.
  - Instantiated twice, once for x and once for y.
- **Top-level glue**: `square_motion` holds the frame strobe, inside test and sync delay pipeline.

## Test plan
- **Reset**: release reset with defaults → `pos_x`=220, `pos_y`=140, all outputs 0 in the first cycle; `square_q`=1 one cycle after (sx,sy)=(220,140); `square_q`=0 for sx=420 and for sy=340.
- **Pipeline alignment**: drive a random hsync/vsync/de pattern → each `_q` equals its input delayed by exactly 1 cycle.
- **Right edge, X0=220, SPEED=1, run=1**: after frame 220 `pos_x`=440, `dx`=1; after frame 221 `pos_x`=439. Bottom edge: after frame 140 `pos_y`=280, `dy`=1; after frame 141 `pos_y`=279.
- **Clamp**: SPEED=7, X0=435 → next frame `pos_x`=440 (clamped, not 442), then 433; left edge from X0=5 moving left → 0, then 7.
- **Freeze**: hold `run`=0 across 3 frames → `pos_x`/`pos_y` unchanged, `frame` still pulses once per frame at (sx,sy)=(0,480)+1 cycle.
- **Reset mid-frame**: assert reset at sy=100 after 50 frames of motion → immediate return to (220,140), directions 0, `square_q`=0.
